// File: rtl/morph_mode_ctrl_if.sv
// Mode-request handshake between host/key logic and the morphology controller.
interface morph_mode_ctrl_if;
  logic [1:0] mode_req;
  logic       mode_req_valid;
  logic       mode_req_ready;

  modport master (output mode_req, mode_req_valid, input mode_req_ready);
  modport slave  (input mode_req, mode_req_valid, output mode_req_ready);
endinterface

// File: rtl/morph_mode_ctrl.sv
// Frame-synchronous mode controller for the erosion/dilation/bypass chain:
// applies mode requests at vsync, drives stage enables, flags malformed frames.
module morph_mode_ctrl #(
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480,
  parameter int DRAIN_CYC = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pre_vsync,
  input  logic             pre_href,
  input  logic             wr_en,
  morph_mode_ctrl_if.slave req,
  output logic [1:0]       active_mode,
  output logic [1:0]       out_sel,
  output logic             ero_en,
  output logic             dil_en,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);
  localparam int          DW     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [11:0] H_W    = 12'(H_ACT);
  localparam logic [11:0] V_LAST = 12'(V_ACT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, WAIT} state_t;

  state_t          state, nstate;
  logic            vsync_d, href_d, vs_rise, href_fall, in_frame, drain_done;
  logic            pending, accept, line_bad;
  logic [1:0]      pend_mode;
  logic [11:0]     pix_cnt, line_cnt;
  logic [DW-1:0]   drain_cnt;

  assign vs_rise            = pre_vsync & ~vsync_d;
  assign href_fall          = ~pre_href & href_d;
  assign in_frame           = (state == ACTIVE) || (state == DRAIN);
  assign req.mode_req_ready = ~pending;
  assign accept             = req.mode_req_valid & ~pending;
  assign out_sel            = active_mode;

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else            state <= nstate;

  // vs_rise wins over every other transition: a sync mid-frame restarts the frame.
  always_comb begin
    nstate     = state;
    drain_done = 1'b0;
    case (state)
      IDLE, WAIT: if (vs_rise) nstate = ACTIVE;
      ACTIVE: begin
        if (vs_rise) nstate = ACTIVE;
        else if (href_fall && line_cnt == V_LAST) nstate = DRAIN;
      end
      DRAIN: begin
        if (vs_rise) nstate = ACTIVE;
        else if (drain_cnt == D_LAST) begin
          nstate     = WAIT;
          drain_done = 1'b1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // vsync_d resets high so a sync already asserted at reset release is not an edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      vsync_d     <= 1'b1;
      href_d      <= 1'b0;
      pending     <= 1'b0;
      pend_mode   <= 2'b00;
      active_mode <= 2'b00;
      ero_en      <= 1'b0;
      dil_en      <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 16'd0;
      pix_cnt     <= 12'd0;
      line_cnt    <= 12'd0;
      line_bad    <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      vsync_d     <= pre_vsync;
      href_d      <= pre_href;
      frame_start <= vs_rise;
      frame_done  <= drain_done;
      frame_err   <= (vs_rise & in_frame) | (drain_done & line_bad);
      ero_en      <= in_frame & active_mode[0];
      dil_en      <= in_frame & active_mode[1];
      if (drain_done) frame_cnt <= frame_cnt + 16'd1;

      // A request accepted on the vs_rise cycle has pending=0 here, so it waits a frame.
      if (vs_rise && pending) begin
        active_mode <= pend_mode;
        pending     <= 1'b0;
      end else if (accept) begin
        pend_mode <= req.mode_req;
        pending   <= 1'b1;
      end

      if (vs_rise) begin
        pix_cnt  <= 12'd0;
        line_cnt <= 12'd0;
        line_bad <= 1'b0;
      end else if (state == ACTIVE) begin
        if (href_fall) begin
          if (pix_cnt != H_W) line_bad <= 1'b1;
          pix_cnt <= 12'd0;
          if (line_cnt != '1) line_cnt <= line_cnt + 12'd1;
        end else if (wr_en && pre_href && pix_cnt != '1) begin
          pix_cnt <= pix_cnt + 12'd1;
        end
      end

      drain_cnt <= (state == DRAIN && !vs_rise) ? drain_cnt + 1'b1 : '0;
    end
endmodule

// File: tb/tb_morph_mode_ctrl.sv
// Directed bench for morph_mode_ctrl with a small frame (8x4, 3-cycle drain).
module tb_morph_mode_ctrl;
  localparam int H = 8, V = 4, D = 3;

  logic        sys_clk = 1'b0, sys_rst_n, pre_vsync, pre_href, wr_en;
  logic [1:0]  active_mode, out_sel;
  logic        ero_en, dil_en, frame_start, frame_done, frame_err;
  logic [15:0] frame_cnt;
  int          errors = 0, checks = 0;
  int          n_start = 0, n_done = 0, n_err = 0, n_ero = 0, n_dil = 0;

  morph_mode_ctrl_if rq();

  morph_mode_ctrl #(.H_ACT(H), .V_ACT(V), .DRAIN_CYC(D)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pre_vsync(pre_vsync),
    .pre_href(pre_href), .wr_en(wr_en), .req(rq), .active_mode(active_mode),
    .out_sel(out_sel), .ero_en(ero_en), .dil_en(dil_en), .frame_start(frame_start),
    .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (frame_start) n_start <= n_start + 1;
    if (frame_done)  n_done  <= n_done + 1;
    if (frame_err)   n_err   <= n_err + 1;
    if (ero_en)      n_ero   <= n_ero + 1;
    if (dil_en)      n_dil   <= n_dil + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick(); @(posedge sys_clk); #1; endtask

  task automatic vs_pulse(); pre_vsync = 1'b1; tick(); pre_vsync = 1'b0; endtask

  task automatic send_line(input int npix, input bit gap);
    pre_href = 1'b1; wr_en = 1'b1;
    repeat (npix) tick();
    pre_href = 1'b0; wr_en = 1'b0;
    tick();
    if (gap) tick();
  endtask

  task automatic run_lines();
    for (int i = 0; i < V - 1; i++) send_line(H, 1'b1);
    send_line(H, 1'b0);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; pre_vsync = 1'b0; pre_href = 1'b0; wr_en = 1'b0;
    rq.mode_req = 2'b00; rq.mode_req_valid = 1'b0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();
    checks++; if (active_mode !== 2'b00) begin errors++; $display("FAIL rst_mode: got %0d want 0", active_mode); end
    checks++; if (out_sel !== 2'b00) begin errors++; $display("FAIL rst_sel: got %0d want 0", out_sel); end
    checks++; if (ero_en !== 1'b0) begin errors++; $display("FAIL rst_ero: got %0d want 0", ero_en); end
    checks++; if (dil_en !== 1'b0) begin errors++; $display("FAIL rst_dil: got %0d want 0", dil_en); end
    checks++; if (rq.mode_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0d want 1", rq.mode_req_ready); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %0d want 0", frame_start); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0d want 0", frame_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0d want 0", frame_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_normal_frame();
    int s0, d0, e0, r0;
    s0 = n_start; d0 = n_done; e0 = n_err; r0 = n_ero + n_dil;
    vs_pulse();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL norm_start: got %0d want 1", frame_start); end
    run_lines();
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL norm_done_early1: got %0d want 0", frame_done); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL norm_done_early2: got %0d want 0", frame_done); end
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL norm_done: got %0d want 1", frame_done); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL norm_cnt: got %0d want 1", frame_cnt); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL norm_done_pulse: got %0d want 0", frame_done); end
    checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL norm_nstart: got %0d want 1", n_start - s0); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL norm_ndone: got %0d want 1", n_done - d0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL norm_nerr: got %0d want 0", n_err - e0); end
    checks++; if (n_ero + n_dil - r0 !== 0) begin errors++; $display("FAIL norm_en: got %0d want 0", n_ero + n_dil - r0); end
  endtask

  task automatic test_mode_open();
    int s_e, s_d;
    vs_pulse();
    send_line(H, 1'b1);
    pre_href = 1'b1; wr_en = 1'b1; rq.mode_req = 2'b11; rq.mode_req_valid = 1'b1;
    tick();
    rq.mode_req_valid = 1'b0;
    checks++; if (rq.mode_req_ready !== 1'b0) begin errors++; $display("FAIL open_ready_drop: got %0d want 0", rq.mode_req_ready); end
    checks++; if (out_sel !== 2'b00) begin errors++; $display("FAIL open_sel_hold: got %0d want 0", out_sel); end
    repeat (H - 1) tick();
    pre_href = 1'b0; wr_en = 1'b0;
    tick(); tick();
    send_line(H, 1'b1); send_line(H, 1'b0);
    repeat (D) tick();
    checks++; if (frame_done !== 1'b1 || out_sel !== 2'b00) begin errors++; $display("FAIL open_first_frame: got done=%0d sel=%0d want done=1 sel=0", frame_done, out_sel); end
    tick();
    s_e = n_ero; s_d = n_dil;
    vs_pulse();
    checks++; if (frame_start !== 1'b1 || out_sel !== 2'b11) begin errors++; $display("FAIL open_apply: got start=%0d sel=%0d want start=1 sel=3", frame_start, out_sel); end
    checks++; if (rq.mode_req_ready !== 1'b1) begin errors++; $display("FAIL open_ready_rise: got %0d want 1", rq.mode_req_ready); end
    checks++; if (ero_en !== 1'b0) begin errors++; $display("FAIL open_ero_late: got %0d want 0", ero_en); end
    run_lines();
    repeat (D) begin
      checks++; if (ero_en !== 1'b1 || dil_en !== 1'b1) begin errors++; $display("FAIL open_drain_en: got ero=%0d dil=%0d want 1 1", ero_en, dil_en); end
      tick();
    end
    checks++; if (frame_done !== 1'b1 || ero_en !== 1'b1) begin errors++; $display("FAIL open_done_en: got done=%0d ero=%0d want 1 1", frame_done, ero_en); end
    tick();
    checks++; if (ero_en !== 1'b0 || dil_en !== 1'b0) begin errors++; $display("FAIL open_en_drop: got ero=%0d dil=%0d want 0 0", ero_en, dil_en); end
    // frame_start edge F; enables high after edges F+1 .. F+42 (last fall sampled at F+39)
    checks++; if (n_ero - s_e !== 42 || n_dil - s_d !== 42) begin errors++; $display("FAIL open_en_cycles: got ero=%0d dil=%0d want 42", n_ero - s_e, n_dil - s_d); end
  endtask

  task automatic test_same_cycle_req();
    pre_vsync = 1'b1; rq.mode_req = 2'b01; rq.mode_req_valid = 1'b1;
    tick();
    pre_vsync = 1'b0; rq.mode_req_valid = 1'b0;
    checks++; if (frame_start !== 1'b1 || active_mode !== 2'b11) begin errors++; $display("FAIL same_old_mode: got start=%0d mode=%0d want 1 3", frame_start, active_mode); end
    checks++; if (rq.mode_req_ready !== 1'b0) begin errors++; $display("FAIL same_ready: got %0d want 0", rq.mode_req_ready); end
    run_lines(); repeat (D + 1) tick();
    vs_pulse();
    checks++; if (active_mode !== 2'b01 || rq.mode_req_ready !== 1'b1) begin errors++; $display("FAIL same_apply: got mode=%0d ready=%0d want 1 1", active_mode, rq.mode_req_ready); end
    tick();
    checks++; if (ero_en !== 1'b1 || dil_en !== 1'b0) begin errors++; $display("FAIL same_en: got ero=%0d dil=%0d want 1 0", ero_en, dil_en); end
    run_lines(); repeat (D + 1) tick();
    checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL same_cnt: got %0d want 5", frame_cnt); end
  endtask

  task automatic test_bad_line();
    vs_pulse();
    send_line(H, 1'b1); send_line(H - 1, 1'b1); send_line(H, 1'b1); send_line(H, 1'b0);
    repeat (D - 1) tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL bad_err_early: got %0d want 0", frame_err); end
    tick();
    checks++; if (frame_done !== 1'b1 || frame_err !== 1'b1) begin errors++; $display("FAIL bad_err: got done=%0d err=%0d want 1 1", frame_done, frame_err); end
    checks++; if (frame_cnt !== 16'd6) begin errors++; $display("FAIL bad_cnt: got %0d want 6", frame_cnt); end
    tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL bad_err_pulse: got %0d want 0", frame_err); end
  endtask

  task automatic test_truncated();
    int d0;
    vs_pulse();
    send_line(H, 1'b1); send_line(H, 1'b1);
    d0 = n_done;
    vs_pulse();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL trunc_err: got %0d want 1", frame_err); end
    checks++; if (frame_cnt !== 16'd6) begin errors++; $display("FAIL trunc_cnt_hold: got %0d want 6", frame_cnt); end
    tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL trunc_err_pulse: got %0d want 0", frame_err); end
    run_lines();
    repeat (D - 1) tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL trunc_done_early: got %0d want 0", frame_done); end
    tick();
    checks++; if (frame_done !== 1'b1 || frame_err !== 1'b0) begin errors++; $display("FAIL trunc_done: got done=%0d err=%0d want 1 0", frame_done, frame_err); end
    checks++; if (frame_cnt !== 16'd7) begin errors++; $display("FAIL trunc_cnt: got %0d want 7", frame_cnt); end
    tick();
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL trunc_ndone: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_reset_in_drain();
    int s0;
    vs_pulse();
    send_line(H, 1'b1);
    rq.mode_req = 2'b10; rq.mode_req_valid = 1'b1;
    tick();
    rq.mode_req_valid = 1'b0;
    checks++; if (rq.mode_req_ready !== 1'b0) begin errors++; $display("FAIL rd_pending: got %0d want 0", rq.mode_req_ready); end
    send_line(H, 1'b1); send_line(H, 1'b1); send_line(H, 1'b0);
    tick();
    checks++; if (ero_en !== 1'b1) begin errors++; $display("FAIL rd_drain_ero: got %0d want 1", ero_en); end
    sys_rst_n = 1'b0; pre_vsync = 1'b1;
    #1;
    checks++; if (active_mode !== 2'b00 || out_sel !== 2'b00) begin errors++; $display("FAIL rd_mode: got mode=%0d sel=%0d want 0 0", active_mode, out_sel); end
    checks++; if (ero_en !== 1'b0 || dil_en !== 1'b0) begin errors++; $display("FAIL rd_en: got ero=%0d dil=%0d want 0 0", ero_en, dil_en); end
    checks++; if (rq.mode_req_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %0d want 1", rq.mode_req_ready); end
    checks++; if (frame_cnt !== 16'd0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rd_frame: got cnt=%0d done=%0d err=%0d want 0 0 0", frame_cnt, frame_done, frame_err); end
    s0 = n_start;
    tick(); tick();
    sys_rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (n_start !== s0) begin errors++; $display("FAIL rd_no_start: got %0d want %0d", n_start, s0); end
    pre_vsync = 1'b0;
    tick();
    vs_pulse();
    checks++; if (frame_start !== 1'b1 || active_mode !== 2'b00) begin errors++; $display("FAIL rd_restart: got start=%0d mode=%0d want 1 0", frame_start, active_mode); end
    tick();
    checks++; if (ero_en !== 1'b0 || dil_en !== 1'b0) begin errors++; $display("FAIL rd_restart_en: got ero=%0d dil=%0d want 0 0", ero_en, dil_en); end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_mode_open();
    test_same_cycle_req();
    test_bad_line();
    test_truncated();
    test_reset_in_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
